// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Arbitrates one fixed-latency single-port memory between instruction fetch and
// the data stage, returning registered read data, a done pulse and pipeline stalls.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              em_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nx;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       if_req_m;
    logic       d_req_m;
    logic       grant_f;
    logic       grant_d;
    logic       last_cycle;

    // A request whose done pulse is showing this cycle has already been served.
    assign if_req_m   = if_req & ~if_done;
    assign d_req_m    = d_req & ~d_done;
    assign if_stall   = if_req_m;
    assign em_stall   = d_req_m;
    assign last_cycle = (state != IDLE) && (lat_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        grant_f  = 1'b0;
        grant_d  = 1'b0;
        case (state)
            IDLE: begin
                if (d_req_m && (!if_req_m || (starve_cnt < STARVE_LIM))) begin
                    grant_d  = 1'b1;
                    state_nx = DATA;
                end else if (if_req_m) begin
                    grant_f  = 1'b1;
                    state_nx = FETCH;
                end
            end
            FETCH, DATA: begin
                if (lat_cnt == 4'd0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
        end else begin
            mem_en  <= grant_f | grant_d;
            if_done <= 1'b0;
            d_done  <= 1'b0;

            if (grant_d) begin
                mem_addr  <= d_addr;
                mem_we    <= d_we;
                mem_wdata <= d_wdata;
                lat_cnt   <= LAT_INIT;
            end else if (grant_f) begin
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
                lat_cnt  <= LAT_INIT;
            end else if ((state != IDLE) && (lat_cnt != 4'd0)) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            // mem_we still describes the access in flight, so stores leave d_rdata alone.
            if (last_cycle && (state == FETCH)) begin
                if_rdata <= mem_rdata;
                if_done  <= 1'b1;
            end
            if (last_cycle && (state == DATA)) begin
                if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
                d_done <= 1'b1;
            end

            if (grant_f || !if_req) begin
                starve_cnt <= 4'd0;
            end else if (grant_d && (starve_cnt != 4'hF)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Randomized and directed bench for mem_port_arbiter: drivers push expected read
// data into queues, a negedge monitor models the memory and the arbitration rules.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 16;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              em_stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .em_stall(em_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] ref_mem [256];
    logic [DATA_W-1:0] phys_mem[256];
    logic [DATA_W-1:0] if_exp_q[$];
    logic [DATA_W-1:0] d_exp_q[$];
    logic [DATA_W-1:0] last_load = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic fetch_txn(input logic [31:0] a, input int gap, output int lat);
        if_addr = a;
        if_req  = 1'b1;
        if_exp_q.push_back(ref_mem[a[7:0]]);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!if_done && lat < 100);
        check("if_done_seen", {31'd0, if_done}, 32'd1);
        if (gap > 0) begin
            if_req = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic data_txn(input logic we, input logic [31:0] a, input logic [15:0] wd,
                            input int gap, output int lat);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        if (we) begin
            ref_mem[a[7:0]] = wd;
        end else begin
            last_load = ref_mem[a[7:0]];
        end
        d_exp_q.push_back(last_load);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!d_done && lat < 100);
        check("d_done_seen", {31'd0, d_done}, 32'd1);
        if (gap > 0) begin
            d_req = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    // ---------------- memory + monitor (negedge) ----------------
    int          cyc = 0;
    int          rd_cyc = -1;
    logic [15:0] rd_val = '0;
    int          exp_en_cyc = -1;
    int          busy_until = -1;
    int          done_cyc = -1;
    int          done_who = 0;
    int          starve_m = 0;
    int          nxt_who = 0;
    logic [31:0] nxt_addr = '0;
    logic        nxt_we = 1'b0;
    logic [15:0] nxt_wdata = '0;

    always @(negedge clk) begin
        logic exp_fd, exp_dd, ireq, dreq, idle;
        if (!rst) begin
            exp_en_cyc = -1;
            busy_until = -1;
            done_cyc   = -1;
            rd_cyc     = -1;
            starve_m   = 0;
            mem_rdata  = 16'($urandom);
        end else begin
            cyc++;
            if (mem_en) begin
                if (mem_we) phys_mem[mem_addr[7:0]] = mem_wdata;
                else begin
                    rd_cyc = cyc + MEM_LAT;
                    rd_val = phys_mem[mem_addr[7:0]];
                end
            end
            mem_rdata = (cyc == rd_cyc) ? rd_val : 16'($urandom);

            // An access occupies the port for MEM_LAT+1 cycles starting at its strobe.
            check("mem_en", {31'd0, mem_en}, {31'd0, cyc == exp_en_cyc});
            if (cyc == exp_en_cyc) begin
                check("mem_addr", mem_addr, nxt_addr);
                check("mem_we", {31'd0, mem_we}, {31'd0, nxt_we});
                if (nxt_we) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, nxt_wdata});
                busy_until = cyc + MEM_LAT;
                done_cyc   = cyc + MEM_LAT + 1;
                done_who   = nxt_who;
            end

            exp_fd = (cyc == done_cyc) && (done_who == 0);
            exp_dd = (cyc == done_cyc) && (done_who == 1);
            check("if_done", {31'd0, if_done}, {31'd0, exp_fd});
            check("d_done", {31'd0, d_done}, {31'd0, exp_dd});
            if (if_done) begin
                if (if_exp_q.size() == 0) check("if_done_unexpected", 32'd1, 32'd0);
                else check("if_rdata", {16'd0, if_rdata}, {16'd0, if_exp_q.pop_front()});
            end
            if (d_done) begin
                if (d_exp_q.size() == 0) check("d_done_unexpected", 32'd1, 32'd0);
                else check("d_rdata", {16'd0, d_rdata}, {16'd0, d_exp_q.pop_front()});
            end
            check("if_stall", {31'd0, if_stall}, {31'd0, if_req & ~exp_fd});
            check("em_stall", {31'd0, em_stall}, {31'd0, d_req & ~exp_dd});

            idle = (cyc > busy_until);
            if (idle) begin
                ireq = if_req && !exp_fd;
                dreq = d_req && !exp_dd;
                if (dreq && (!ireq || starve_m < STARVE_MAX)) begin
                    exp_en_cyc = cyc + 1;
                    nxt_who    = 1;
                    nxt_addr   = d_addr;
                    nxt_we     = d_we;
                    nxt_wdata  = d_wdata;
                    if (if_req) starve_m = (starve_m < 15) ? starve_m + 1 : 15;
                end else if (ireq) begin
                    exp_en_cyc = cyc + 1;
                    nxt_who    = 0;
                    nxt_addr   = if_addr;
                    nxt_we     = 1'b0;
                    starve_m   = 0;
                end
            end
            if (!if_req) starve_m = 0;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat_f, lat_d, n;
        logic [31:0] a;
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = 16'($urandom);
            phys_mem[i] = ref_mem[i];
        end
        #1;
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_if_rdata", {16'd0, if_rdata}, 32'd0);
        check("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
        check("rst_dones", {30'd0, if_done, d_done}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Lone fetch
        fetch_txn(32'h10, 2, lat_f);
        check("lone_fetch_lat", lat_f, MEM_LAT + 2);

        // Collision: data wins, fetch follows
        fork
            fetch_txn(32'h40, 2, lat_f);
            data_txn(1'b0, 32'h20, 16'h0, 2, lat_d);
        join
        check("collide_d_lat", lat_d, MEM_LAT + 2);
        check("collide_f_lat", lat_f, 2 * (MEM_LAT + 2));

        // Store, then read it back
        data_txn(1'b1, 32'h30, 16'h5A5A, 1, lat_d);
        check("store_lat", lat_d, MEM_LAT + 2);
        data_txn(1'b0, 32'h30, 16'h0, 1, lat_d);

        // Both requesters held back-to-back
        fork
            for (int i = 0; i < 4; i++) fetch_txn(32'h50 + i, (i == 3) ? 1 : 0, lat_f);
            for (int i = 0; i < 5; i++) data_txn(1'b0, 32'h90 + i, 16'h0, (i == 4) ? 1 : 0, lat_d);
        join

        // Randomized traffic
        fork
            for (int i = 0; i < 30; i++) begin
                logic [31:0] fa;
                fa = $urandom; fa[7] = 1'b0;
                fetch_txn(fa, $urandom_range(0, 3), lat_f);
            end
            for (int i = 0; i < 30; i++) begin
                logic [31:0] da;
                logic        we;
                we = 1'($urandom_range(0, 1));
                da = $urandom;
                if (we) da[7] = 1'b1;
                data_txn(we, da, 16'($urandom), $urandom_range(0, 3), lat_d);
            end
        join
        repeat (2) @(posedge clk); #1;
        check("if_q_empty", if_exp_q.size(), 32'd0);
        check("d_q_empty", d_exp_q.size(), 32'd0);

        // Reset in the cycle after mem_en abandons the access
        d_we = 1'b0; d_addr = 32'h85; d_req = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!mem_en && n < 20);
        check("rst_test_grant", {31'd0, mem_en}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("arst_mem_en", {31'd0, mem_en}, 32'd0);
        check("arst_mem_we", {31'd0, mem_we}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("arst_if_rdata", {16'd0, if_rdata}, 32'd0);
        check("arst_d_rdata", {16'd0, d_rdata}, 32'd0);
        check("arst_dones", {30'd0, if_done, d_done}, 32'd0);
        d_req = 1'b0;
        last_load = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_done_after_rst", {30'd0, if_done, d_done}, 32'd0);
        end
        fetch_txn(32'h11, 2, lat_f);
        check("post_rst_fetch_lat", lat_f, MEM_LAT + 2);
        check("final_q_empty", if_exp_q.size() + d_exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores driven from the E/M pipeline register).
- Sequences each access through a fixed-latency memory.
- Returns read data and a one-cycle done pulse to the requester.
- Generates stall signals that freeze the F/D and E/M pipeline buffers until the requester's access completes.

Parameters:
- ADDR_W, 32, address width (matches PC width)
- DATA_W, 16, memory word width
- MEM_LAT, 2, cycles from mem_en to mem_rdata valid; legal range 1..15
- STARVE_MAX, 3, consecutive data grants allowed while fetch is waiting; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, registered
- if_done  out  1  one-cycle completion pulse
- if_stall  out  1  hold F/D buffer
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_done  out  1  one-cycle completion pulse
- em_stall  out  1  hold E/M buffer
- mem_en  out  1  access strobe, one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en

Behaviour:
- States: IDLE, FETCH, DATA. Counters: lat_cnt (4 bits), starve_cnt (4 bits).
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - mem_en, mem_we, mem_addr, mem_wdata = 0.
  - if_rdata, d_rdata = 0.
  - if_done, d_done = 0.
  - lat_cnt, starve_cnt = 0.
  - Reset during an access abandons it: no done pulse is produced, and the requester must re-request.
- Arbitration in IDLE, using requests sampled this cycle:
  - Data wins when d_req=1 and (if_req=0 or starve_cnt<STARVE_MAX).
  - Otherwise fetch wins when if_req=1.
  - Otherwise the block stays in IDLE.
- Masking: in a cycle where if_done=1, if_req is ignored for arbitration; in a cycle where d_done=1, d_req is ignored. This prevents regranting a request that has just completed.
- Grant at edge T→T+1:
  - state = FETCH or DATA; lat_cnt = MEM_LAT.
  - In cycle T+1: mem_en=1, and mem_addr/mem_we/mem_wdata are loaded from the winner's inputs.
  - Fetch grants force mem_we=0.
  - mem_en is high for exactly one cycle per grant; mem_addr, mem_we and mem_wdata hold their values until the next grant.
- Busy states: lat_cnt decrements each cycle. In the cycle where lat_cnt==0, mem_rdata is captured:
  - into if_rdata for FETCH;
  - into d_rdata for a DATA load;
  - nothing is captured for a store (d_rdata holds its value).
- Completion:
  - On the next edge, state = IDLE and the matching done pulse is high for one cycle.
  - The done cycle is an IDLE cycle, so the next grant can be decided in it.
  - Request-to-done latency is MEM_LAT+2 cycles; back-to-back throughput is one access per MEM_LAT+2 cycles.
- starve_cnt:
  - Increments (saturating at 15) on each data grant made while if_req=1.
  - Clears on a fetch grant.
  - Clears in any cycle with if_req=0.
- Stall outputs (combinational): if_stall = if_req & ~if_done; em_stall = d_req & ~d_done.
- Requests arriving while the block is busy wait. Their inputs must stay stable until the grant.

Test Plan:
1. Reset: assert rst=0 mid-run → all registered outputs 0 and state IDLE immediately, with no clock needed.
2. Lone fetch (MEM_LAT=2): if_req=1, if_addr=0x10 at cycle 1; mem_rdata=0xABCD at cycle 4 → mem_en=1 and mem_addr=0x10 in cycle 2; if_done=1 and if_rdata=0xABCD in cycle 5; if_stall=1 in cycles 1–4 and 0 in cycle 5.
3. Collision: if_req and d_req (load, d_addr=0x20) both rise at cycle 1 → data mem_en in cycle 2 and d_done in cycle 5; fetch mem_en in cycle 6 and if_done in cycle 9; em_stall falls in cycle 5, if_stall falls in cycle 9.
4. Starvation (STARVE_MAX=3): d_req held with a fresh request after every d_done, if_req held high throughout → exactly 3 data grants, then a fetch grant, then starve_cnt=0 and data wins again.
5. Store: d_req=1, d_we=1, d_addr=0x30, d_wdata=0x5A5A → mem_en=1, mem_we=1, mem_wdata=0x5A5A in one cycle; d_done after MEM_LAT+2 cycles; d_rdata unchanged.
6. Reset mid-access: rst=0 in the cycle after mem_en, then released → no done pulse; a subsequent lone fetch completes with normal latency.
